sprite_draw_arbiter: RTL and testbench
======================================

// Module: sprite_draw_arbiter
// PURPOSE
//  Shares one VGA pixel-plot port and one sprite-memory read port among NREQ requesters.
//  Each requester asks for a full sprite draw: an (x,y) origin plus an object select.
//  The block arbitrates round-robin and scans the 2^SPR_LOG2 x 2^SPR_LOG2 sprite memory.
//  It emits VGA_X/VGA_Y/VGA_COLOR/plot aligned to the 1-cycle memory latency, then pulses done.
//  It sits between the game logic (board and piece drawers) and the DESim VGA outputs.
// PARAMETERS
//  NREQ      4  number of requesters (>=2)
//  OBJW      1  width of object-select field (2^OBJW sprite memories, muxed externally)
//  SPR_LOG2  3  log2 of sprite side; default 8x8 = 64 pixels
//  TRANS_COL 0  3-bit colour treated as transparent (used only with SPRITE_ARB_TRANSPARENT_EN)
// PORTS
//  Clock      in   1              system clock (CLOCK_50)
//  Resetn     in   1              reset, synchronous, active-low
//  req        in   NREQ           level request; bit i held high until grant[i]
//  req_x      in   NREQ*8         origin x of requester i at [8i+7:8i]
//  req_y      in   NREQ*7         origin y of requester i at [7i+6:7i]
//  req_obj    in   NREQ*OBJW      object select of requester i
//  grant      out  NREQ           one-hot, 1-cycle pulse: request i accepted, operands latched
//  busy       out  1              high from grant through the last plot cycle
//  done       out  1              1-cycle pulse after the last pixel of a draw
//  mem_addr   out  2*SPR_LOG2     sprite memory address {YC,XC}
//  mem_sel    out  OBJW           latched object select of the current draw
//  mem_q      in   3              sprite memory data; registered, valid 1 cycle after mem_addr
//  VGA_X      out  8              pixel x = latched x + XC (mod 256)
//  VGA_Y      out  7              pixel y = latched y + YC (mod 128)
//  VGA_COLOR  out  3              = mem_q (combinational pass-through, aligned with plot)
//  plot       out  1              pixel write strobe
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, counter 0.
//   grant/busy/done/plot 0; VGA_X/VGA_Y/mem_addr/mem_sel 0.
//  States: IDLE -> DRAW -> FLUSH -> IDLE.
//  IDLE: if any req, select the first asserted bit at or after rr pointer (cyclic).
//   On that edge: latch x/y/obj, grant[i]<=1 for one cycle, cnt<=0, ->DRAW, ptr<=(i+1)%NREQ.
//   No req: stay IDLE, pointer unchanged.
//  DRAW: mem_addr=cnt ({YC,XC}, XC = low SPR_LOG2 bits).
//   Each edge: VGA_X<=x+XC, VGA_Y<=y+YC, plot<=1, cnt<=cnt+1.
//   When cnt = all-ones: ->FLUSH.
//  FLUSH: plot stays 1 for the last pixel; ->IDLE; done<=1 for one cycle.
//  Timing: grant cycle G. plot high for 64 consecutive cycles G+2..G+65 (default size).
//   done high at G+66; busy high G+1..G+65.
//  done cycle is IDLE: a pending req is arbitrated in the same cycle (back-to-back, no gap).
//  Coordinate add truncates: no clipping, wraps mod 256 / mod 128.
//   Off-screen x (>=160) is still strobed.
//  req deasserted before grant: dropped, no draw.
//   req still high at done: treated as a new request.
//  req/req_x/req_y/req_obj changes during a draw are ignored; latched operands are used.
//  Resetn low mid-draw: next edge forces reset values, aborts the draw.
//   No done for the aborted draw; no further plot.
//  mem_sel holds constant from grant+1 through FLUSH.
// CONFIGURATION
//  SPRITE_ARB_TRANSPARENT_EN defined:
//   plot forced 0 in any cycle where mem_q == TRANS_COL.
//   Timing, busy and done are unchanged.
//  Undefined: every pixel is plotted, including TRANS_COL; TRANS_COL is unused.
// TESTING
//  1. Reset, req=0001, x=10, y=20: grant[0] at G.
//     64 plots; first (10,20), last (17,27); addresses 0..63 in order; done at G+66.
//  2. req=1111 held: grants 0,1,2,3,0 in order, each draw back-to-back.
//     done and the next grant in the same cycle.
//  3. x=254, y=126: pixels wrap to (0..5,0..5) region; VGA_X=1 for XC=3; no clipping.
//  4. Assert Resetn=0 at 30th plot: plot/busy 0 next cycle, no done, ptr=0.
//     A new req after reset draws fully.
//  5. SPRITE_ARB_TRANSPARENT_EN, sprite with 10 pixels =TRANS_COL: 54 plot strobes.
//     done still at G+66. Without the macro: 64 strobes.
//  6. req[2] pulsed 1 cycle while req[1] draws: no grant[2]. req changed mid-draw: latched x/y kept.

Source files
------------

// File: rtl/sprite_draw_arbiter_if.sv
// Bus bundle between the sprite draw arbiter, its requesters, the sprite memory
// and the VGA pixel-plot outputs. The arbiter side uses the slave modport.
interface sprite_draw_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int OBJW     = 1,
  parameter int SPR_LOG2 = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ*8-1:0]      req_x;
  logic [NREQ*7-1:0]      req_y;
  logic [NREQ*OBJW-1:0]   req_obj;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   done;
  logic [2*SPR_LOG2-1:0]  mem_addr;
  logic [OBJW-1:0]        mem_sel;
  logic [2:0]             mem_q;
  logic [7:0]             VGA_X;
  logic [6:0]             VGA_Y;
  logic [2:0]             VGA_COLOR;
  logic                   plot;

  modport slave (
    input  req, req_x, req_y, req_obj, mem_q,
    output grant, busy, done, mem_addr, mem_sel, VGA_X, VGA_Y, VGA_COLOR, plot
  );

  modport master (
    output req, req_x, req_y, req_obj, mem_q,
    input  grant, busy, done, mem_addr, mem_sel, VGA_X, VGA_Y, VGA_COLOR, plot
  );
endinterface

// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one sprite-memory read
// port and one VGA pixel-plot port. A granted request scans the whole sprite
// (2^SPR_LOG2 x 2^SPR_LOG2) and plots each pixel at origin + {YC,XC}, aligned
// to the one-cycle memory latency, then pulses done.
// Optional feature macro: SPRITE_ARB_TRANSPARENT_EN (suppress plot where the
// sprite colour equals TRANS_COL).
module sprite_draw_arbiter #(
  parameter int         NREQ      = 4,
  parameter int         OBJW      = 1,
  parameter int         SPR_LOG2  = 3,
  parameter logic [2:0] TRANS_COL = 3'd0
) (
  input logic Clock,
  input logic Resetn,
  sprite_draw_arbiter_if.slave bus
);

  localparam int AW = 2 * SPR_LOG2;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SPRITE_ARB_TRANSPARENT_EN
  localparam logic TRANS_EN = 1'b1;
`else
  localparam logic TRANS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [OBJW-1:0]   obj_q, obj_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              addr_v_q, addr_v_d;
  logic              plot_q, plot_d;
  logic [7:0]        vga_x_q, vga_x_d;
  logic [6:0]        vga_y_q, vga_y_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     idx;
  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic [OBJW-1:0]   sel_obj;
  logic              arb_open;

  // Pick the first asserted request at or after the rotating pointer and mux its operands.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    sel_x   = '0;
    sel_y   = '0;
    sel_obj = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_x   = bus.req_x[i*8 +: 8];
        sel_y   = bus.req_y[i*7 +: 7];
        sel_obj = bus.req_obj[i*OBJW +: OBJW];
      end
    end
  end

  // Next-state logic: the address stage scans the sprite, the pixel stage follows one cycle later.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    obj_d      = obj_q;
    grant_d    = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_addr_d = mem_addr_q;
    addr_v_d   = 1'b0;
    plot_d     = addr_v_q;
    vga_x_d    = x_q + 8'(mem_addr_q[SPR_LOG2-1:0]);
    vga_y_d    = y_q + 7'(mem_addr_q[AW-1:SPR_LOG2]);
    arb_open   = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        arb_open = 1'b1;
      end
      DRAW: begin
        mem_addr_d = cnt_q;
        addr_v_d   = 1'b1;
        busy_d     = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (addr_v_q) begin
          busy_d = 1'b1;
        end else begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
          arb_open = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_open && found) begin
      grant_d = NREQ'(1) << win;
      x_d     = sel_x;
      y_d     = sel_y;
      obj_d   = sel_obj;
      cnt_d   = '0;
      state_d = DRAW;
      ptr_d   = PW'((int'(win) + 1) % NREQ);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      obj_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      addr_v_q   <= 1'b0;
      plot_q     <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      obj_q      <= obj_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      addr_v_q   <= addr_v_d;
      plot_q     <= plot_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_sel   = obj_q;
  assign bus.VGA_X     = vga_x_q;
  assign bus.VGA_Y     = vga_y_q;
  assign bus.VGA_COLOR = bus.mem_q;
  assign bus.plot      = plot_q & ~(TRANS_EN & (bus.mem_q == TRANS_COL));

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Testbench for sprite_draw_arbiter: directed scenarios plus randomized requests,
// checked every cycle against a timeline model of each draw (grant at G, busy
// G+1..G+65, pixel k plotted at G+2+k, done at G+66).
module tb_sprite_draw_arbiter;

  localparam int         NREQ     = 4;
  localparam int         OBJW     = 1;
  localparam int         SPR_LOG2 = 3;
  localparam logic [2:0] TRANS    = 3'd0;

  logic Clock;
  logic Resetn;

  sprite_draw_arbiter_if #(.NREQ(NREQ), .OBJW(OBJW), .SPR_LOG2(SPR_LOG2)) bus ();

  sprite_draw_arbiter #(
    .NREQ(NREQ), .OBJW(OBJW), .SPR_LOG2(SPR_LOG2), .TRANS_COL(TRANS)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  logic [2:0] sprite_mem [0:1][0:63];

  int n_compared   = 0;
  int n_mismatched = 0;
  logic check_en   = 1'b0;

  // Model of the draw timeline
  logic             m_active   = 1'b0;
  int               m_g        = 0;
  int               m_ptr      = 0;
  int               m_who      = 0;
  int               m_x        = 0;
  int               m_y        = 0;
  logic             m_obj      = 1'b0;
  logic             m_done_now = 1'b0;
  int               obs_plots  = 0;
  int               exp_plots  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Registered sprite memory: data valid one cycle after the address.
  always @(posedge Clock) begin
    bus.mem_q <= sprite_mem[bus.mem_sel][bus.mem_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] pattern);
    bus.req = pattern;
  endtask

  task automatic set_operands(input int i, input logic [7:0] x, input logic [6:0] y, input logic obj);
    bus.req_x[i*8 +: 8]       = x;
    bus.req_y[i*7 +: 7]       = y;
    bus.req_obj[i*OBJW +: 1]  = obj;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < NREQ; i++) begin
      set_operands(i, 8'($urandom), 7'($urandom), 1'($urandom));
    end
  endtask

  task automatic request_until_grant(input int i, input int limit);
    logic got;
    logic [NREQ-1:0] g;
    got = 1'b0;
    bus.req = bus.req | (NREQ'(1) << i);
    for (int c = 0; c < limit && !got; c++) begin
      wait_cycles(1);
      g = bus.grant >> i;
      if (g[0]) got = 1'b1;
    end
    bus.req = bus.req & ~(NREQ'(1) << i);
    check_output("grant_wait", 32'(got), 32'd1);
  endtask

  // Cycle-by-cycle comparison against the draw timeline, then advance the model.
  always @(negedge Clock) begin
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] rq;
    logic            pix_on;
    logic            exp_plot;
    logic            can_arb;
    logic            picked;
    logic [5:0]      kk;
    logic [2:0]      col;
    int              k;
    int              idx;
    if (check_en) begin
      exp_grant = '0;
      if (m_active && m_g == 0) exp_grant = NREQ'(1) << m_who;
      check_output("grant", 32'(bus.grant), 32'(exp_grant));
      check_output("busy", 32'(bus.busy), 32'(m_active && m_g >= 1 && m_g <= 65));
      check_output("done", 32'(bus.done), 32'(m_done_now));
      pix_on   = m_active && m_g >= 2 && m_g <= 65;
      exp_plot = pix_on;
      if (pix_on) begin
        k   = m_g - 2;
        kk  = 6'(k);
        col = sprite_mem[m_obj][kk];
        check_output("vga_x", 32'(bus.VGA_X), 32'((m_x + (k % 8)) % 256));
        check_output("vga_y", 32'(bus.VGA_Y), 32'((m_y + (k / 8)) % 128));
        check_output("vga_color", 32'(bus.VGA_COLOR), 32'(col));
`ifdef SPRITE_ARB_TRANSPARENT_EN
        if (col == TRANS) exp_plot = 1'b0;
`endif
      end
      check_output("plot", 32'(bus.plot), 32'(exp_plot));
      if (m_active && m_g >= 1 && m_g <= 64) begin
        check_output("mem_addr", 32'(bus.mem_addr), 32'(m_g - 1));
        check_output("mem_sel", 32'(bus.mem_sel), 32'(m_obj));
      end
      if (bus.plot) obs_plots++;

      if (!Resetn) begin
        m_active   = 1'b0;
        m_ptr      = 0;
        m_done_now = 1'b0;
        obs_plots  = 0;
      end else begin
        m_done_now = m_active && (m_g == 65);
        can_arb    = !m_active || (m_g == 65);
        if (m_active && m_g == 65) begin
          check_output("plot_count", 32'(obs_plots), 32'(exp_plots));
        end
        if (can_arb && bus.req != '0) begin
          picked = 1'b0;
          for (int j = 0; j < NREQ; j++) begin
            idx = (m_ptr + j) % NREQ;
            rq  = bus.req >> idx;
            if (!picked && rq[0]) begin
              picked = 1'b1;
              m_who  = idx;
            end
          end
          m_x       = int'(bus.req_x[m_who*8 +: 8]);
          m_y       = int'(bus.req_y[m_who*7 +: 7]);
          m_obj     = bus.req_obj[m_who*OBJW +: 1];
          m_ptr     = (m_who + 1) % NREQ;
          m_active  = 1'b1;
          m_g       = 0;
          obs_plots = 0;
          exp_plots = 64;
`ifdef SPRITE_ARB_TRANSPARENT_EN
          exp_plots = 0;
          for (int p = 0; p < 64; p++) begin
            if (sprite_mem[m_obj][6'(p)] != TRANS) exp_plots++;
          end
`endif
        end else if (m_active) begin
          if (m_g == 65) m_active = 1'b0;
          else m_g++;
        end
      end
    end
  end

  initial begin
    int placed;
    int p;
    Resetn      = 1'b0;
    bus.req     = '0;
    bus.req_x   = '0;
    bus.req_y   = '0;
    bus.req_obj = '0;

    // Object 0: exactly ten transparent pixels; object 1: fully random colours.
    for (int i = 0; i < 64; i++) begin
      sprite_mem[0][i] = 3'($urandom_range(1, 7));
      sprite_mem[1][i] = 3'($urandom_range(0, 7));
    end
    placed = 0;
    while (placed < 10) begin
      p = $urandom_range(0, 63);
      if (sprite_mem[0][p] != TRANS) begin
        sprite_mem[0][p] = TRANS;
        placed++;
      end
    end

    // Reset and its quiescent outputs
    @(posedge Clock);
    #1;
    check_en = 1'b1;
    @(negedge Clock);
    check_output("rst_vga_x", 32'(bus.VGA_X), 32'd0);
    check_output("rst_vga_y", 32'(bus.VGA_Y), 32'd0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
    wait_cycles(2);
    Resetn = 1'b1;
    wait_cycles(2);

    // Single draw from requester 0 at (10,20) with the ten-transparent sprite
    set_operands(0, 8'd10, 7'd20, 1'b0);
    request_until_grant(0, 5);
    wait_cycles(70);

    // All four requesting continuously; operands churn during draws
    randomize_operands();
    apply_stimulus(4'b1111);
    for (int c = 0; c < 340; c++) begin
      wait_cycles(1);
      randomize_operands();
    end
    apply_stimulus(4'b0000);
    wait_cycles(70);

    // Coordinate wrap near the top corner
    set_operands(3, 8'd254, 7'd126, 1'b1);
    request_until_grant(3, 5);
    wait_cycles(70);

    // Reset in the middle of a draw at the 30th plot
    set_operands(1, 8'($urandom), 7'($urandom), 1'b1);
    request_until_grant(1, 5);
    wait_cycles(31);
    Resetn = 1'b0;
    wait_cycles(1);
    Resetn = 1'b1;
    wait_cycles(1);

    // Pointer restarts at 0: requesters 1 and 3 pending, 1 wins, 3 follows back-to-back
    set_operands(1, 8'd40, 7'd50, 1'b0);
    set_operands(3, 8'd150, 7'd100, 1'b1);
    apply_stimulus(4'b1010);
    wait_cycles(1);
    apply_stimulus(4'b1000);
    wait_cycles(70);
    apply_stimulus(4'b0000);
    wait_cycles(70);

    // Short pulse on requester 2 and operand change while requester 1 draws
    set_operands(1, 8'd100, 7'd60, 1'b1);
    apply_stimulus(4'b0010);
    wait_cycles(1);
    apply_stimulus(4'b0000);
    wait_cycles(20);
    set_operands(1, 8'd5, 7'd5, 1'b0);
    set_operands(2, 8'd77, 7'd33, 1'b0);
    apply_stimulus(4'b0100);
    wait_cycles(1);
    apply_stimulus(4'b0000);
    wait_cycles(70);

    // Randomized request traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) apply_stimulus(4'($urandom_range(0, 15)));
      randomize_operands();
      wait_cycles(1);
    end
    apply_stimulus(4'b0000);
    wait_cycles(140);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
